// File: rtl/ramen_order_arbiter.sv
// Round-robin arbiter sharing one ramen kitchen core between four ticket windows,
// serialising each order into the core's type/portion protocol and sequencing the day close.
module ramen_order_arbiter #(
   parameter int N_WIN   = 4,
   parameter int TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_WIN-1:0]     win_req,
   input  logic [2*N_WIN-1:0]   win_type,
   input  logic [N_WIN-1:0]     win_portion,
   output logic [N_WIN-1:0]     win_ack,
   output logic [N_WIN-1:0]     win_done,
   output logic                 win_success,
   input  logic                 close_req,
   output logic                 core_in_valid,
   output logic [1:0]           core_ramen_type,
   output logic                 core_portion,
   output logic                 core_selling,
   input  logic                 core_out_valid_order,
   input  logic                 core_success,
   input  logic                 core_out_valid_tot,
   input  logic [27:0]          core_sold_num,
   input  logic [14:0]          core_total_gain,
   output logic                 day_valid,
   output logic [27:0]          day_sold,
   output logic [14:0]          day_gain,
   output logic [7:0]           day_rejects,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE_T, ISSUE_P, WAIT_RES, WAIT_TOT, REPORT
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       rr_q, rr_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       type_q, type_d;
   logic             portion_q, portion_d;
   logic             close_pend_q, close_pend_d;
   logic [7:0]       rej_q, rej_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [N_WIN-1:0] done_q, done_d;
   logic             success_q, success_d;
   logic             terr_q, terr_d;
   logic [27:0]      sold_q, sold_d;
   logic [14:0]      gain_q, gain_d;

   logic             grant_found;
   logic [1:0]       grant_idx;
   logic             closing;
   logic             wd_expired;

   assign closing    = close_pend_q | close_req;
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   // Scan from the highest offset down so the lowest offset from rr_q wins.
   always_comb begin : grant_search
      logic [1:0] idx;
      grant_found = 1'b0;
      grant_idx   = rr_q;
      for (int k = N_WIN - 1; k >= 0; k--) begin
         idx = rr_q + 2'(k);
         if (win_req[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   // NOTE: every *_d gets a default before the case so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      grant_d      = grant_q;
      type_d       = type_q;
      portion_d    = portion_q;
      close_pend_d = close_pend_q;
      rej_d        = rej_q;
      wd_d         = '0;
      done_d       = '0;
      success_d    = 1'b0;
      terr_d       = terr_q;
      sold_d       = sold_q;
      gain_d       = gain_q;

      unique case (state_q)
         IDLE: begin
            if (closing) begin
               sold_d  = '0;
               gain_d  = '0;
               state_d = REPORT;
            end else if (grant_found) begin
               grant_d   = grant_idx;
               type_d    = win_type[{grant_idx, 1'b0} +: 2];
               portion_d = win_portion[grant_idx];
               rr_d      = grant_idx + 2'd1;
               state_d   = ISSUE_T;
            end
         end
         ISSUE_T: begin
            if (close_req) close_pend_d = 1'b1;
            state_d = ISSUE_P;
         end
         ISSUE_P: begin
            if (close_req) close_pend_d = 1'b1;
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (close_req) close_pend_d = 1'b1;
            if (core_out_valid_order) begin
               done_d    = N_WIN'(1) << grant_q;
               success_d = core_success;
               if (!core_success && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
               state_d   = closing ? WAIT_TOT : IDLE;
            end else if (wd_expired) begin
               terr_d  = 1'b1;
               done_d  = N_WIN'(1) << grant_q;
               if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         WAIT_TOT: begin
            if (core_out_valid_tot) begin
               sold_d  = core_sold_num;
               gain_d  = core_total_gain;
               state_d = REPORT;
            end else if (wd_expired) begin
               terr_d  = 1'b1;
               sold_d  = '0;
               gain_d  = '0;
               state_d = REPORT;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         REPORT: begin
            close_pend_d = 1'b0;
            rej_d        = '0;
            rr_d         = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         grant_q      <= '0;
         type_q       <= '0;
         portion_q    <= 1'b0;
         close_pend_q <= 1'b0;
         rej_q        <= '0;
         wd_q         <= '0;
         done_q       <= '0;
         success_q    <= 1'b0;
         terr_q       <= 1'b0;
         sold_q       <= '0;
         gain_q       <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         grant_q      <= grant_d;
         type_q       <= type_d;
         portion_q    <= portion_d;
         close_pend_q <= close_pend_d;
         rej_q        <= rej_d;
         wd_q         <= wd_d;
         done_q       <= done_d;
         success_q    <= success_d;
         terr_q       <= terr_d;
         sold_q       <= sold_d;
         gain_q       <= gain_d;
      end
   end

   assign win_ack         = (state_q == ISSUE_T) ? (N_WIN'(1) << grant_q) : '0;
   assign win_done        = done_q;
   assign win_success     = success_q;
   assign core_in_valid   = (state_q == ISSUE_T) || (state_q == ISSUE_P);
   assign core_ramen_type = (state_q == ISSUE_T) ? type_q : 2'd0;
   assign core_portion    = (state_q == ISSUE_P) && portion_q;
   // Selling drops only while the core reports the last order of the day.
   assign core_selling    = !((state_q == WAIT_RES) && core_out_valid_order && closing);
   assign day_valid       = (state_q == REPORT);
   assign day_sold        = (state_q == REPORT) ? sold_q : '0;
   assign day_gain        = (state_q == REPORT) ? gain_q : '0;
   assign day_rejects     = (state_q == REPORT) ? rej_q : '0;
   assign busy            = (state_q != IDLE);
   assign timeout_err     = terr_q;

endmodule

// File: tb/tb_ramen_order_arbiter.sv
// Scoreboard bench for ramen_order_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares every ack, core beat, done and day report.
module tb_ramen_order_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  win_req;
   logic [7:0]  win_type;
   logic [3:0]  win_portion;
   logic [3:0]  win_ack;
   logic [3:0]  win_done;
   logic        win_success;
   logic        close_req;
   logic        core_in_valid;
   logic [1:0]  core_ramen_type;
   logic        core_portion;
   logic        core_selling;
   logic        core_out_valid_order;
   logic        core_success;
   logic        core_out_valid_tot;
   logic [27:0] core_sold_num;
   logic [14:0] core_total_gain;
   logic        day_valid;
   logic [27:0] day_sold;
   logic [14:0] day_gain;
   logic [7:0]  day_rejects;
   logic        busy;
   logic        timeout_err;

   ramen_order_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .win_req(win_req), .win_type(win_type), .win_portion(win_portion),
      .win_ack(win_ack), .win_done(win_done), .win_success(win_success),
      .close_req(close_req),
      .core_in_valid(core_in_valid), .core_ramen_type(core_ramen_type),
      .core_portion(core_portion), .core_selling(core_selling),
      .core_out_valid_order(core_out_valid_order), .core_success(core_success),
      .core_out_valid_tot(core_out_valid_tot), .core_sold_num(core_sold_num),
      .core_total_gain(core_total_gain),
      .day_valid(day_valid), .day_sold(day_sold), .day_gain(day_gain),
      .day_rejects(day_rejects), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [3:0]  ack_q[$];
   logic [4:0]  done_q[$];
   logic [2:0]  beat_q[$];
   logic [50:0] day_q[$];
   logic        exp_sell_low = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (rst_n) begin
         if (win_ack != 4'd0) begin
            if (ack_q.size() == 0) check("ack_unexpected", 64'(win_ack), 64'd0);
            else check("ack", 64'(win_ack), 64'(ack_q.pop_front()));
         end
         if (win_done != 4'd0) begin
            if (done_q.size() == 0) check("done_unexpected", 64'(win_done), 64'd0);
            else check("done", 64'({win_done, win_success}), 64'(done_q.pop_front()));
         end
         if (core_in_valid) begin
            if (beat_q.size() == 0) check("beat_unexpected", 64'(core_in_valid), 64'd0);
            else check("core_beat", 64'({core_ramen_type, core_portion}), 64'(beat_q.pop_front()));
         end else if (core_ramen_type != 2'd0 || core_portion) begin
            check("core_idle_zero", 64'({core_ramen_type, core_portion}), 64'd0);
         end
         if (day_valid) begin
            if (day_q.size() == 0) check("day_unexpected", 64'(day_valid), 64'd0);
            else check("day_report", 64'({day_sold, day_gain, day_rejects}), 64'(day_q.pop_front()));
         end else if (day_sold != 28'd0 || day_gain != 15'd0 || day_rejects != 8'd0) begin
            check("day_idle_zero", 64'({day_sold, day_gain, day_rejects}), 64'd0);
         end
         if (core_out_valid_order || !core_selling)
            check("core_selling", 64'(core_selling), 64'(!exp_sell_low));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_order(input int w, input logic [1:0] t, input logic p);
      ack_q.push_back(4'(1 << w));
      beat_q.push_back({t, 1'b0});
      beat_q.push_back({2'd0, p});
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (win_ack == 4'd0 && n < 20);
      if (win_ack == 4'd0) check("ack_timeout", 64'd0, 64'd1);
   endtask

   // Called in the ISSUE_T cycle; answers the order from the core side.
   task automatic answer(input logic succ, input logic close_p, input logic last);
      tick();
      if (close_p) close_req = 1'b1;
      tick();
      close_req            = 1'b0;
      core_out_valid_order = 1'b1;
      core_success         = succ;
      exp_sell_low         = last;
      tick();
      core_out_valid_order = 1'b0;
      core_success         = 1'b0;
      exp_sell_low         = 1'b0;
      check("done_latency", 64'(win_done != 4'd0), 64'd1);
   endtask

   task automatic single(input int w, input logic [1:0] t, input logic p, input logic succ,
                         input logic close_p, input logic last);
      int n;
      push_order(w, t, p);
      done_q.push_back({4'(1 << w), succ});
      win_req[w]            = 1'b1;
      win_type[2*w +: 2]    = t;
      win_portion[w]        = p;
      wait_ack(n);
      check("ack_latency", 64'(n), 64'd1);
      win_req[w] = 1'b0;
      answer(succ, close_p, last);
   endtask

   task automatic give_tot(input logic [27:0] sold, input logic [14:0] gain);
      core_out_valid_tot = 1'b1;
      core_sold_num      = sold;
      core_total_gain    = gain;
      tick();
      core_out_valid_tot = 1'b0;
      core_sold_num      = '0;
      core_total_gain    = '0;
      check("report_after_tot", 64'(day_valid), 64'd1);
      tick();
   endtask

   task automatic idle_close();
      close_req = 1'b1;
      tick();
      close_req = 1'b0;
      check("report_after_close", 64'(day_valid), 64'd1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got %0d expected 0 at %0t", 1, $time);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      win_req = '0; win_type = '0; win_portion = '0; close_req = 1'b0;
      core_out_valid_order = 1'b0; core_success = 1'b0; core_out_valid_tot = 1'b0;
      core_sold_num = '0; core_total_gain = '0;

      // Reset state
      #12;
      check("reset_outputs", 64'({win_ack, win_done, win_success, core_in_valid, core_ramen_type,
                                  core_portion, day_valid, busy, timeout_err}), 64'd0);
      check("reset_day", 64'({day_sold, day_gain, day_rejects}), 64'd0);
      check("reset_selling", 64'(core_selling), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // Zero-order close: core never sees an order
      day_q.push_back({28'd0, 15'd0, 8'd0});
      idle_close();
      check("idle_after_close", 64'(busy), 64'd0);

      // Fairness: all four request continuously, grants 0,1,2,3,0
      win_type    = {2'd3, 2'd2, 2'd1, 2'd0};
      win_portion = 4'b1010;
      push_order(0, 2'd0, 1'b0); done_q.push_back({4'b0001, 1'b1});
      push_order(1, 2'd1, 1'b1); done_q.push_back({4'b0010, 1'b1});
      push_order(2, 2'd2, 1'b0); done_q.push_back({4'b0100, 1'b1});
      push_order(3, 2'd3, 1'b1); done_q.push_back({4'b1000, 1'b1});
      push_order(0, 2'd0, 1'b0); done_q.push_back({4'b0001, 1'b1});
      win_req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         wait_ack(n);
         if (i == 4) win_req = 4'h0;
         answer(1'b1, 1'b0, 1'b0);
      end

      // Pointer now 1: window 2 alone twice (second grant wraps 3->0->1->2)
      single(2, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      single(2, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);

      // Single order: window 0, type 2, portion 1, accepted
      single(0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

      // Close during an order in the ISSUE_P cycle
      single(3, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
      day_q.push_back({28'h0204081, 15'd1050, 8'd0});
      give_tot(28'h0204081, 15'd1050);

      // Three rejected orders, then close in IDLE
      single(0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      single(1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      single(2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      day_q.push_back({28'd0, 15'd0, 8'd3});
      idle_close();

      // Next day: pointer back at 0, so windows 0 and 3 together grant 0 first
      win_type    = {2'd2, 2'd0, 2'd0, 2'd3};
      win_portion = 4'b1000;
      push_order(0, 2'd3, 1'b0); done_q.push_back({4'b0001, 1'b1});
      push_order(3, 2'd2, 1'b1); done_q.push_back({4'b1000, 1'b0});
      win_req = 4'b1001;
      wait_ack(n);
      win_req[0] = 1'b0;
      answer(1'b1, 1'b0, 1'b0);
      wait_ack(n);
      win_req[3] = 1'b0;
      answer(1'b0, 1'b0, 1'b0);

      // close_req and win_req in the same IDLE cycle: close wins, request waits
      day_q.push_back({28'd0, 15'd0, 8'd1});
      push_order(1, 2'd2, 1'b1); done_q.push_back({4'b0010, 1'b1});
      win_type[3:2] = 2'd2;
      win_portion[1] = 1'b1;
      win_req[1] = 1'b1;
      close_req  = 1'b1;
      tick();
      close_req = 1'b0;
      check("close_wins_report", 64'(day_valid), 64'd1);
      check("close_wins_no_ack", 64'(win_ack), 64'd0);
      wait_ack(n);
      check("held_req_ack_latency", 64'(n), 64'd2);
      win_req[1] = 1'b0;
      answer(1'b1, 1'b0, 1'b0);

      // Watchdog in WAIT_RES: core never answers
      push_order(1, 2'd3, 1'b1);
      done_q.push_back({4'b0010, 1'b0});
      win_type[3:2] = 2'd3;
      win_req[1] = 1'b1;
      wait_ack(n);
      win_req[1] = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (win_done == 4'd0 && n < 200);
      check("wd_res_latency", 64'(n), 64'd65);
      check("timeout_err_set", 64'(timeout_err), 64'd1);
      repeat (5) tick();
      check("timeout_err_sticky", 64'(timeout_err), 64'd1);

      // Watchdog in WAIT_TOT: totals never arrive, report with zero totals
      single(2, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      day_q.push_back({28'd0, 15'd0, 8'd1});
      n = 0;
      do begin
         tick();
         n++;
      end while (!day_valid && n < 200);
      check("wd_tot_latency", 64'(n), 64'd63);
      tick();

      // Reset mid-order: no done for the aborted order, sticky flag cleared
      push_order(3, 2'd1, 1'b1);
      win_type[7:6] = 2'd1;
      win_portion[3] = 1'b1;
      win_req[3] = 1'b1;
      wait_ack(n);
      win_req[3] = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check("rst_selling", 64'(core_selling), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();

      check("queues_drained", 64'(ack_q.size() + done_q.size() + beat_q.size() + day_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
